// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator: 1-bit PDM strobes in, one saturated 19-bit signed PCM sample
// out every DECIM accepted bits, with the first STAGES (unsettled) samples hidden.
module pdm_cic_decimator #(
    parameter int DECIM  = 64,
    parameter int STAGES = 3,
    parameter int ACC_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pdm_valid,
    input  logic                    pdm_data,
    output logic signed [18:0]      pcm_data,
    output logic                    pcm_valid
);

    localparam int OUT_W  = 19;
    localparam int CNT_W  = $clog2(DECIM);
    localparam int WARM_W = $clog2(STAGES + 1);

    localparam logic [CNT_W-1:0]         LAST_PHASE = CNT_W'(DECIM - 1);
    localparam logic [WARM_W-1:0]        WARM_DONE  = WARM_W'(STAGES);
    localparam logic signed [ACC_W-1:0]  POS_LIM    = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  NEG_LIM    = ACC_W'(-(2 ** (OUT_W - 1)));

    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] integ     [STAGES];
    logic signed [ACC_W-1:0] integ_nxt [STAGES];
    logic        [CNT_W-1:0] phase;
    logic                    dec_evt;

    // comb_p[0] holds the captured integrator value; comb_p[k] is the output of comb stage k
    logic signed [ACC_W-1:0] comb_p [STAGES];
    logic signed [ACC_W-1:0] dly    [STAGES];
    logic                    vld_p  [STAGES];
    logic signed [ACC_W-1:0] comb_last;
    logic        [WARM_W-1:0] warm;

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (v > POS_LIM)
            return POS_LIM[OUT_W-1:0];
        else if (v < NEG_LIM)
            return NEG_LIM[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    assign x = pdm_data ? ACC_W'(1) : {ACC_W{1'b1}};

    always_comb begin
        logic signed [ACC_W-1:0] acc;
        acc = x;
        for (int k = 0; k < STAGES; k++) begin
            acc          = integ[k] + acc;
            integ_nxt[k] = acc;
        end
    end

    assign dec_evt   = pdm_valid && (phase == LAST_PHASE);
    assign comb_last = comb_p[STAGES-1] - dly[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            warm      <= '0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                integ[k]  <= '0;
                comb_p[k] <= '0;
                dly[k]    <= '0;
                vld_p[k]  <= 1'b0;
            end
        end else begin
            pcm_valid <= 1'b0;

            // integrator section: advances only on accepted bits
            if (pdm_valid) begin
                phase <= phase + 1'b1;
                for (int k = 0; k < STAGES; k++)
                    integ[k] <= integ_nxt[k];
            end

            // p0: capture the last integrator including the DECIM-th bit
            vld_p[0] <= dec_evt;
            if (dec_evt)
                comb_p[0] <= integ_nxt[STAGES-1];

            // p1..p(STAGES-1): comb stages, each moved only by the token
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) begin
                    comb_p[k] <= comb_p[k-1] - dly[k-1];
                    dly[k-1]  <= comb_p[k-1];
                end
            end

            // final comb stage lands directly in the saturated output register
            if (vld_p[STAGES-1]) begin
                dly[STAGES-1] <= comb_p[STAGES-1];
                pcm_data      <= sat_out(comb_last);
                pcm_valid     <= (warm == WARM_DONE);
                if (warm != WARM_DONE)
                    warm <= warm + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator: table of constant-density streams plus
// hand-written sequences (warm-up value, async reset mid-stream, density step).
module tb_pdm_cic_decimator;

    localparam int DECIM  = 64;
    localparam int STAGES = 3;
    localparam int ACC_W  = 20;
    localparam int POS_FS = 262143;
    localparam int NEG_FS = -262144;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pdm_valid = 1'b0;
    logic               pdm_data = 1'b0;
    logic signed [18:0] pcm_data;
    logic               pcm_valid;

    pdm_cic_decimator #(.DECIM(DECIM), .STAGES(STAGES), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .pdm_valid(pdm_valid), .pdm_data(pdm_data),
        .pcm_data(pcm_data), .pcm_valid(pcm_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model and scoreboard
    typedef struct { int val; int due; } exp_t;
    exp_t sb[$];

    logic signed [ACC_W-1:0] mi [STAGES];
    logic signed [ACC_W-1:0] md [STAGES];
    int mph;
    int mwarm;

    task automatic model_reset();
        for (int k = 0; k < STAGES; k++) begin
            mi[k] = '0;
            md[k] = '0;
        end
        mph   = 0;
        mwarm = 0;
        sb.delete();
    endtask

    task automatic model_bit(input bit b, input int acc_edge);
        logic signed [ACC_W-1:0] xv, y, t;
        int s;
        xv = b ? ACC_W'(1) : ACC_W'(-1);
        mi[0] = mi[0] + xv;
        for (int k = 1; k < STAGES; k++) mi[k] = mi[k] + mi[k-1];
        if (mph == DECIM - 1) begin
            mph = 0;
            y = mi[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                t = y - md[k];
                md[k] = y;
                y = t;
            end
            s = int'(y);
            if (s > POS_FS) s = POS_FS;
            if (s < NEG_FS) s = NEG_FS;
            if (mwarm == STAGES) sb.push_back('{s, acc_edge + STAGES});
            else mwarm++;
        end else begin
            mph++;
        end
    endtask

    // drive one accepted bit, then gap-1 idle cycles
    task automatic send_bit(input bit b, input int gap);
        @(negedge clk);
        pdm_valid = 1'b1;
        pdm_data  = b;
        model_bit(b, cyc + 1);
        if (gap > 1) begin
            @(negedge clk);
            pdm_valid = 1'b0;
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    // output monitor
    int  pulses = 0;
    int  last_pulse = 0;
    int  first_pulse = 0;
    int  exp_space = 0;
    bit  chk_const = 0;
    int  exp_const = 0;
    bit  chk_mono = 0;
    int  prev_val = 0;
    bit  prev_valid = 0;
    int  vals[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n && pcm_valid) begin
            check("pulse_width", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sample_value", int'(pcm_data), mon_e.val);
                check("sample_time", cyc, mon_e.due);
            end
            if (chk_const) check("settled_value", int'(pcm_data), exp_const);
            if (exp_space > 0 && pulses > 0) check("pulse_spacing", cyc - last_pulse, exp_space);
            if (chk_mono && pulses > 0) check("monotonic", int'(int'(pcm_data) >= prev_val), 1);
            if (pulses == 0) first_pulse = cyc;
            prev_val   = int'(pcm_data);
            last_pulse = cyc;
            pulses++;
            vals.push_back(int'(pcm_data));
        end
        prev_valid = pcm_valid;
    end

    task automatic clear_monitor();
        pulses = 0;
        prev_valid = 0;
        vals.delete();
        chk_const = 0;
        exp_space = 0;
        chk_mono = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pdm_valid = 1'b0;
        pdm_data = 1'b0;
        model_reset();
        clear_monitor();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic finish_stream(input string name, input int exp_pulses);
        @(negedge clk);
        pdm_valid = 1'b0;
        repeat (8) @(negedge clk);
        check({name, "_drained"}, sb.size(), 0);
        check({name, "_pulses"}, pulses, exp_pulses);
    endtask

    typedef struct { int pat; int gap; int nev; int exp_val; string name; } vec_t;
    vec_t tbl[4];

    initial begin
        bit b;
        bit hit;
        int first_edge;

        tbl[0] = '{0, 1, 8, POS_FS, "ones"};
        tbl[1] = '{1, 1, 7, NEG_FS, "zeros"};
        tbl[2] = '{2, 1, 7, 0,      "alternating"};
        tbl[3] = '{0, 4, 7, POS_FS, "ones_gap4"};

        model_reset();
        #12;
        check("reset_pcm_data", int'(pcm_data), 0);
        check("reset_pcm_valid", int'(pcm_valid), 0);

        // first decimated sample of an all-ones stream: C(66,3), written but hidden
        do_reset();
        for (int i = 0; i < DECIM; i++) send_bit(1'b1, 1);
        @(negedge clk);
        pdm_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("warmup_data", int'(pcm_data), 45760);
        check("warmup_valid", int'(pcm_valid), 0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            chk_const = 1;
            exp_const = tbl[v].exp_val;
            exp_space = DECIM * tbl[v].gap;
            for (int i = 0; i < tbl[v].nev * DECIM; i++) begin
                case (tbl[v].pat)
                    0: b = 1'b1;
                    1: b = 1'b0;
                    default: b = (i % 2 == 0);
                endcase
                send_bit(b, tbl[v].gap);
            end
            finish_stream(tbl[v].name, tbl[v].nev - STAGES);
        end

        // asynchronous reset while a visible pulse is on the output, pdm_valid continuous
        do_reset();
        hit = 0;
        for (int i = 0; i < 6 * DECIM && !hit; i++) begin
            send_bit(1'b1, 1);
            @(posedge clk);
            #2;
            if (pcm_valid) begin
                hit = 1;
                rst_n = 1'b0;
                #1;
                check("async_rst_valid", int'(pcm_valid), 0);
                check("async_rst_data", int'(pcm_data), 0);
            end
        end
        check("reset_pulse_seen", int'(hit), 1);
        model_reset();
        clear_monitor();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pdm_data = 1'b1;
        first_edge = cyc + 1;
        model_bit(1'b1, first_edge);
        chk_const = 1;
        exp_const = POS_FS;
        exp_space = DECIM;
        for (int i = 1; i < 5 * DECIM; i++) send_bit(1'b1, 1);
        finish_stream("restart", 5 - STAGES);
        // pulse lands STAGES edges after the edge carrying the 256th bit
        check("restart_first_pulse", first_pulse - first_edge, 4 * DECIM - 1 + STAGES);

        // density step: 512 zeros then ones
        do_reset();
        chk_mono = 1;
        for (int i = 0; i < 8 * DECIM; i++) send_bit(1'b0, 1);
        for (int i = 0; i < 8 * DECIM; i++) send_bit(1'b1, 1);
        finish_stream("step", 16 - STAGES);
        check("step_samples", vals.size(), 13);
        if (vals.size() >= 13) begin
            check("step_before", vals[4], NEG_FS);
            check("step_third_after", vals[7], POS_FS);
            check("step_final", vals[12], POS_FS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
